product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
Downstream stage of the 4x4 combinational multiplier. It consumes the 8-bit Product of successive operand pairs through a valid/ready handshake and sums COUNT consecutive products into a block sum. It presents each block sum on a valid/ready output port. Typical use is dot-product and energy computations fed by the multiplier array.

Parameters:
PROD_W, 8, width of incoming product (multiplier output width)
COUNT, 16, products summed per block (>=1)
CNT_W, 4, beat counter width; 2^CNT_W >= COUNT required
ACC_W, 12, Sum width; default holds 16*225=3600 without overflow

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
clear  input  1  synchronous abort of current block; lower priority than rst
Product  input  PROD_W  product from multiplier, unsigned
in_valid  input  1  Product valid this cycle
in_ready  output  1  block accepts Product this cycle
Sum  output  ACC_W  block sum, unsigned, registered
Overflow  output  1  block sum exceeded 2^ACC_W-1 (registered with Sum)
out_valid  output  1  Sum/Overflow valid
out_ready  input  1  consumer accepts Sum this cycle

Behaviour:
- Interface: one clock; reset is synchronous and active-high. rst is sampled on the rising edge of clk.
- Reset values: state=ACCUM, acc=0, cnt=0, ovf_acc=0, in_ready=1, out_valid=0, Sum=0, Overflow=0.
- in_ready is decoded from the registered state only: it is 1 in ACCUM and 0 in HOLD. It has no combinational path from out_ready.
- A beat is accepted when in_valid & in_ready. Product is sampled at that edge. When in_ready=0, in_valid and Product are ignored.
- ACCUM, accepted beat, cnt < COUNT-1: acc <= (acc+Product) mod 2^ACC_W; cnt++. ovf_acc is set if the carry out of ACC_W is 1. ovf_acc is sticky within the block.
- ACCUM, accepted beat, cnt == COUNT-1 (last beat):
  - Sum <= (acc+Product) mod 2^ACC_W.
  - Overflow <= ovf_acc | carry.
  - out_valid <= 1; state <= HOLD.
  - acc, cnt and ovf_acc are cleared to 0.
- Latency: Sum is valid in the cycle after the last beat is accepted.
- COUNT=1: every accepted beat produces a Sum equal to Product.
- HOLD: Sum, Overflow and out_valid are held stable until out_valid & out_ready. On that edge, out_valid <= 0 and state <= ACCUM, so in_ready=1 in the following cycle.
- No input is accepted in the handshake cycle. Minimum period is COUNT+1 cycles per block.
- While in HOLD, out_valid never drops without a handshake, except on rst or clear.
- clear (rst=0): acc, cnt and ovf_acc are cleared; out_valid <= 0; state <= ACCUM. Sum and Overflow keep their last values. A beat presented in the same cycle as clear is discarded.
- rst in any state, including mid-block or in HOLD, restores all reset values on the next edge. rst has priority over clear, in_valid and out_ready.
- Arithmetic: unsigned. The internal adder is ACC_W+1 bits wide; bit ACC_W is the carry. Product is zero-extended to ACC_W.

Test Plan:
1. After rst, drive 16 beats of Product=225 (from A=B=15) on consecutive cycles with out_ready=1. Required: in_ready=1 throughout; out_valid=1 exactly one cycle after the 16th beat; Sum=3600 (0xE10); Overflow=0; in_ready=1 two cycles after the 16th beat.
2. Gapped input: Products 1..16 with in_valid toggling 1/0. Required: Sum=136, asserted one cycle after the 16th accepted beat.
3. Backpressure: complete a block with out_ready=0 for 5 cycles while in_valid=1 and Product=7. Required: in_ready=0, with Sum and out_valid stable for all 5 cycles and beats ignored. Raise out_ready: out_valid falls at the next edge. The next block of 16x7 yields Sum=112.
4. Overflow, with ACC_W=8 and COUNT=4: 4 beats of 100. Required: Sum=144 (400 mod 256) and Overflow=1. The next block of 4x1 gives Sum=4 and Overflow=0.
5. Pulse clear after 7 beats of 50, with in_valid=1 in the clear cycle. Required: no out_valid. The following 16 beats of 1 give Sum=16, proving the partial sum and the clear-cycle beat were discarded.
6. Assert rst for one cycle while in HOLD with Sum=3600. Required: next cycle out_valid=0, Sum=0, Overflow=0, in_ready=1. A fresh 16-beat block then completes normally.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive multiplier products into a block sum and presents it
// on a valid/ready port. The carry out of the accumulator is kept as a sticky overflow flag.
module product_accumulator #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned COUNT  = 16,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned ACC_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [PROD_W-1:0] Product,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  Sum,
    output logic              Overflow,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_acc;

    logic [SUM_W-1:0]   sum_c;
    logic               carry_c;
    logic               accept_c;
    logic               last_c;

    // One extra adder bit captures the carry out of the accumulator width.
    assign sum_c    = SUM_W'(acc) + SUM_W'(Product);
    assign carry_c  = sum_c[ACC_W];
    assign accept_c = in_valid & in_ready;
    assign last_c   = (cnt == CNT_W'(COUNT - 1));

    // in_ready is a flop that always mirrors (state == ACCUM).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Sum       <= '0;
            Overflow  <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept_c) begin
                        if (last_c) begin
                            Sum       <= sum_c[ACC_W-1:0];
                            Overflow  <= ovf_acc | carry_c;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= HOLD;
                            acc       <= '0;
                            cnt       <= '0;
                            ovf_acc   <= 1'b0;
                        end else begin
                            acc     <= sum_c[ACC_W-1:0];
                            cnt     <= cnt + CNT_W'(1);
                            ovf_acc <= ovf_acc | carry_c;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default 16-beat/12-bit instance
// plus a 4-beat/8-bit instance for the overflow case.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, out_ready;
    logic [7:0]  Product;
    logic        in_ready, Overflow, out_valid;
    logic [11:0] Sum;

    logic        rst8, clear8, in_valid8, out_ready8;
    logic [7:0]  product8;
    logic        in_ready8, overflow8, out_valid8;
    logic [7:0]  sum8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk(clk), .rst(rst), .clear(clear), .Product(Product),
        .in_valid(in_valid), .in_ready(in_ready), .Sum(Sum),
        .Overflow(Overflow), .out_valid(out_valid), .out_ready(out_ready)
    );

    product_accumulator #(.PROD_W(8), .COUNT(4), .CNT_W(2), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst8), .clear(clear8), .Product(product8),
        .in_valid(in_valid8), .in_ready(in_ready8), .Sum(sum8),
        .Overflow(overflow8), .out_valid(out_valid8), .out_ready(out_ready8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consecutive beats of a constant product; out_valid must rise only after the last.
    task automatic run_block(input string tag, input int n, input logic [7:0] p);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            Product  = p;
            chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
            tick();
            if (i < n - 1) chk({tag, " early out_valid"}, 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; Product = '0;
        rst8 = 1'b1; clear8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1; product8 = '0;
        tick(); tick();
        rst = 1'b0; rst8 = 1'b0;

        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset Sum", 32'(Sum), 32'd0);
        chk("reset Overflow", 32'(Overflow), 32'd0);

        // 1: sixteen beats of 225
        run_block("t1", 16, 8'd225);
        chk("t1 Sum", 32'(Sum), 32'd3600);
        chk("t1 Overflow", 32'(Overflow), 32'd0);
        chk("t1 hold in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t1 out_valid drop", 32'(out_valid), 32'd0);
        chk("t1 in_ready back", 32'(in_ready), 32'd1);

        // 2: gapped beats 1..16, junk on idle cycles
        for (int k = 1; k <= 16; k++) begin
            in_valid = 1'b1;
            Product  = 8'(k);
            tick();
            in_valid = 1'b0;
            Product  = 8'hFF;
            if (k < 16) begin
                chk("t2 early out_valid", 32'(out_valid), 32'd0);
                tick();
            end
        end
        chk("t2 out_valid", 32'(out_valid), 32'd1);
        chk("t2 Sum", 32'(Sum), 32'd136);
        tick();
        chk("t2 out_valid drop", 32'(out_valid), 32'd0);

        // 3: backpressure with beats offered during HOLD
        out_ready = 1'b0;
        run_block("t3a", 16, 8'd7);
        chk("t3 Sum", 32'(Sum), 32'd112);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            Product  = 8'd7;
            chk("t3 hold in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("t3 hold out_valid", 32'(out_valid), 32'd1);
            chk("t3 hold Sum", 32'(Sum), 32'd112);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t3 out_valid drop", 32'(out_valid), 32'd0);
        chk("t3 in_ready back", 32'(in_ready), 32'd1);
        run_block("t3b", 16, 8'd7);
        chk("t3 second Sum", 32'(Sum), 32'd112);
        tick();

        // 4: overflow on the narrow instance, 400 mod 256 = 144
        for (int k = 0; k < 4; k++) begin
            in_valid8 = 1'b1;
            product8  = 8'd100;
            tick();
            if (k < 3) chk("t4 early out_valid", 32'(out_valid8), 32'd0);
        end
        in_valid8 = 1'b0;
        chk("t4 out_valid", 32'(out_valid8), 32'd1);
        chk("t4 Sum", 32'(sum8), 32'd144);
        chk("t4 Overflow", 32'(overflow8), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            in_valid8 = 1'b1;
            product8  = 8'd1;
            tick();
        end
        in_valid8 = 1'b0;
        chk("t4b out_valid", 32'(out_valid8), 32'd1);
        chk("t4b Sum", 32'(sum8), 32'd4);
        chk("t4b Overflow", 32'(overflow8), 32'd0);
        tick();

        // 5: clear after seven beats of 50, beat in the clear cycle discarded
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            Product  = 8'd50;
            tick();
        end
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t5 no out_valid", 32'(out_valid), 32'd0);
        chk("t5 Sum kept", 32'(Sum), 32'd112);
        chk("t5 in_ready", 32'(in_ready), 32'd1);
        run_block("t5", 16, 8'd1);
        chk("t5 Sum", 32'(Sum), 32'd16);
        chk("t5 Overflow", 32'(Overflow), 32'd0);
        tick();

        // 6: reset while holding a result
        out_ready = 1'b0;
        run_block("t6a", 16, 8'd225);
        tick();
        chk("t6 held out_valid", 32'(out_valid), 32'd1);
        chk("t6 held Sum", 32'(Sum), 32'd3600);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 rst out_valid", 32'(out_valid), 32'd0);
        chk("t6 rst Sum", 32'(Sum), 32'd0);
        chk("t6 rst Overflow", 32'(Overflow), 32'd0);
        chk("t6 rst in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        run_block("t6b", 16, 8'd225);
        chk("t6 fresh Sum", 32'(Sum), 32'd3600);
        tick();
        chk("t6 final out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
